sram_page_ecc_decoder: RTL and testbench
========================================

# sram_page_ecc_decoder

Parametrised SECDED decoder for SRAM pages. It sits on the SRAM read path between the page read sequencer and the egress logic. It accepts one page of PAGE_WORDS words plus its check code as a valid/ready stream, then corrects any single-bit error (data or code) and detects double-bit errors. It emits the corrected page on a second valid/ready stream through a two-page ping-pong buffer, so ingest of page n+1 overlaps drain of page n.

## Interface
- DATA_W, 16, bits per word (≥2)
- PAGE_WORDS, 8, words per page (power of two, ≥2)
- CNT_W, 16, width of the saturating error counters
- Derived: N = DATA_W*PAGE_WORDS. CHK_W is the smallest c with 2^c ≥ N+c+1 (8 for the defaults). CODE_W = CHK_W+1.
- Reset: one clock; reset is asynchronous and active-low.
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- cfg_ecc_en, in, 1, 0 = bypass (no correction, no flags); sampled on each page's first accepted beat
- in_valid, in, 1, input beat valid
- in_ready, out, 1, input beat accepted when in_valid&&in_ready
- in_data, in, DATA_W, page word, word 0 first
- in_code, in, CODE_W, page code; sampled only on the page's final beat
- out_valid, out, 1, corrected word valid
- out_ready, in, 1, downstream accept
- out_data, out, DATA_W, corrected word
- out_last, out, 1, high on word PAGE_WORDS-1
- out_err_corr, out, 1, page had one corrected error; constant across the page
- out_err_uncorr, out, 1, page uncorrectable; constant across the page
- out_err_word, out, log2(PAGE_WORDS), word index of the flipped data bit (0 if none)
- out_err_bit, out, log2(DATA_W), bit index of the flipped data bit (0 if none)
- corr_cnt, out, CNT_W, saturating count of corrected pages
- uncorr_cnt, out, CNT_W, saturating count of uncorrectable pages

## Operation
- **Bit numbering.** Page bit i = word*DATA_W + bit. Data bit i maps to position pos(i), the (i+1)-th integer ≥3 that is not a power of two (3,5,6,7,9,…). Check bit k maps to position 2^k.
- **Code format.** in_code[k] (k<CHK_W) = XOR of the data bits whose pos has bit k set. in_code[CHK_W] = even parity over all N data bits and all CHK_W check bits.
- **Accumulation.** Per accepted beat: syndrome ^= XOR of pos(i) over the set bits of the word; parity ^= reduction XOR of the word. The word is written into the fill buffer at the beat counter index. Beat counter wraps at PAGE_WORDS; there is no in_last.
- **Final beat.** syndrome ^= the check bits whose in_code bit is set (each contributes position 2^k); parity ^= XOR of in_code. Result S, P (P=1 means mismatch) is registered with the buffer, and the fill buffer is marked full.
- **Classification.**
  - S=0, P=0: clean.
  - P=1 and S=0, or P=1 and S a power of two: code-bit error. Data unchanged; err_corr=1.
  - P=1 and S = pos(i) for some i<N: flip bit i on output; err_corr=1; err_word/err_bit = i / DATA_W, i % DATA_W.
  - P=0 and S≠0, or P=1 and S beyond pos(N-1): err_uncorr=1; data is output raw.
- **Bypass.** cfg_ecc_en=0 on the page's first beat means the page is output raw with both flags 0 and counters untouched.
- **Counters.** Increment by one on each out_last handshake of a flagged page; saturate at all-ones.
- **Buffers.** Two page buffers, filled and drained in alternation.
  - Buffer states per buffer: EMPTY → FILLING (first beat) → FULL (final beat) → DRAINING (selected for output) → EMPTY (out_last handshake).
  - in_ready = 1 iff the current fill buffer is EMPTY or FILLING.
  - The drain side reads words in order; the pointer advances only on out_valid&&out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, all flags/indices 0, both counters 0, both buffers EMPTY, syndrome/parity/beat counters 0.
- Reset is asynchronous and may assert mid-page or mid-drain. All partial pages are discarded and the outputs return to reset values immediately. The first beat after deassertion is word 0.
- Latency: final beat accepted at edge t → word 0 visible with out_valid=1 after edge t+1, if the drain side is idle.
- Throughput: one word per cycle each side. A buffer freed at an out_last handshake at edge t accepts input from edge t onward (in_ready high in the cycle after t).
- out_* are registered and stable while out_valid&&!out_ready. Flags are valid on every word of the page.
- Counters update at the edge of the out_last handshake.

## Test plan
- All-zero page, in_code=0, out_ready=1 → 8 words of 0x0000, out_last on word 7, no flags, out_valid 2 cycles after the final beat.
- Encoded random page with word 3 bit 5 flipped (i=53) → word 3 restored, err_corr=1, err_word=3, err_bit=5, corr_cnt=1.
- Two data bits flipped (word 0 bit 0, word 6 bit 15) → raw data out, err_uncorr=1, uncorr_cnt=1, corr_cnt unchanged.
- in_code[2] flipped only → data unchanged, err_corr=1, err_word=0, err_bit=0. Separately, in_code[8] flipped only → same response.
- out_ready=0 while three pages are offered back-to-back → in_ready drops after the 16th beat. Raising out_ready drains pages 1, 2, 3 in order with correct data.
- rst_n pulsed low during beat 4 of page 1 → outputs reset asynchronously. A following full page decodes clean with no stale words.

Source files
------------

// File: rtl/sram_page_ecc_decoder.sv
// SECDED page decoder on the SRAM read path. Two ping-pong page buffers let
// ingest of one page overlap the registered drain of the previous one.
module sram_page_ecc_decoder #(
  parameter int DATA_W     = 16,
  parameter int PAGE_WORDS = 8,
  parameter int CNT_W      = 16,
  localparam int N         = DATA_W * PAGE_WORDS,
  localparam int CHK_C0    = $clog2(N + 1),
  localparam int CHK_W     = ((1 << CHK_C0) >= N + CHK_C0 + 1) ? CHK_C0 : CHK_C0 + 1,
  localparam int CODE_W    = CHK_W + 1,
  localparam int WORD_W    = $clog2(PAGE_WORDS),
  localparam int BIT_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_ecc_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err_corr,
  output logic              out_err_uncorr,
  output logic [WORD_W-1:0] out_err_word,
  output logic [BIT_W-1:0]  out_err_bit,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [3:0]        dbg_buf_state
);

  localparam int IDX_W = $clog2(N);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both
  // high; valid never depends on ready, and out_* hold while out_valid && !out_ready.

  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL, BUF_DRAINING} buf_state_t;

  typedef struct packed {
    logic              corr;
    logic              uncorr;
    logic              flip;
    logic [WORD_W-1:0] word;
    logic [BIT_W-1:0]  bit_i;
  } meta_t;

  // Hamming position of data bit i: the (i+1)-th integer >= 3 that is not a power of two.
  function automatic int pos_of(input int i);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 3; p < i + 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == i && res == 0) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  logic [CHK_W-1:0] pos_tab [N];
  for (genvar g = 0; g < N; g++) begin : g_pos
    localparam int P = pos_of(g);
    assign pos_tab[g] = CHK_W'(P);
  end

  buf_state_t        state_q [2];
  buf_state_t        state_nxt [2];
  meta_t             meta_q [2];
  meta_t             meta_fin;
  logic [DATA_W-1:0] mem_q [2][PAGE_WORDS];
  logic              fill_sel_q, drain_sel_q;
  logic [WORD_W-1:0] beat_q, rd_ptr_q;
  logic [CHK_W-1:0]  syn_q, word_syn, syn_fin;
  logic              par_q, par_fin, page_en_q;
  logic              in_fire, beat_last, out_fire, drain_done;
  logic              load_en, load_first, load_sel;
  logic [WORD_W-1:0] load_idx;
  logic [DATA_W-1:0] load_mask, load_data;
  logic [IDX_W-1:0]  base_idx;
  logic              is_pow2;
  int                msb, flip_idx;

  assign in_ready   = (state_q[fill_sel_q] == BUF_EMPTY) || (state_q[fill_sel_q] == BUF_FILLING);
  assign in_fire    = in_valid && in_ready;
  assign beat_last  = (beat_q == WORD_W'(PAGE_WORDS - 1));
  assign out_fire   = out_valid && out_ready;
  assign drain_done = out_fire && out_last;
  assign dbg_buf_state = {state_q[1], state_q[0]};

  always_comb begin
    word_syn = '0;
    base_idx = IDX_W'(beat_q) * IDX_W'(DATA_W);
    for (int b = 0; b < DATA_W; b++) begin
      if (in_data[b]) word_syn = word_syn ^ pos_tab[base_idx + IDX_W'(b)];
    end
  end

  // Each set check bit k contributes position 2^k, so the code bits XOR in directly.
  assign syn_fin = syn_q ^ word_syn ^ in_code[CHK_W-1:0];
  assign par_fin = par_q ^ (^in_data) ^ (^in_code);

  always_comb begin
    meta_fin = '0;
    msb      = 0;
    for (int k = 0; k < CHK_W; k++) begin
      if (syn_fin[k]) msb = k;
    end
    is_pow2  = ((syn_fin & (syn_fin - CHK_W'(1))) == '0);
    flip_idx = int'(syn_fin) - 2 - msb;
    if (page_en_q && (syn_fin != '0 || par_fin)) begin
      if (!par_fin) begin
        meta_fin.uncorr = 1'b1;
      end else if (is_pow2) begin
        meta_fin.corr = 1'b1;
      end else if (flip_idx < N) begin
        meta_fin.corr  = 1'b1;
        meta_fin.flip  = 1'b1;
        meta_fin.word  = WORD_W'(flip_idx / DATA_W);
        meta_fin.bit_i = BIT_W'(flip_idx % DATA_W);
      end else begin
        meta_fin.uncorr = 1'b1;
      end
    end
  end

  // Drain side: pick the next word to present in the output register.
  always_comb begin
    load_en    = 1'b0;
    load_first = 1'b0;
    load_sel   = drain_sel_q;
    load_idx   = '0;
    if (!out_valid) begin
      if (state_q[drain_sel_q] == BUF_FULL) begin
        load_en    = 1'b1;
        load_first = 1'b1;
      end
    end else if (out_fire) begin
      if (!out_last) begin
        load_en  = 1'b1;
        load_idx = rd_ptr_q + WORD_W'(1);
      end else if (state_q[~drain_sel_q] == BUF_FULL) begin
        load_en    = 1'b1;
        load_first = 1'b1;
        load_sel   = ~drain_sel_q;
      end
    end
  end

  always_comb begin
    load_mask = '0;
    if (meta_q[load_sel].flip && meta_q[load_sel].word == load_idx)
      load_mask[meta_q[load_sel].bit_i] = 1'b1;
    load_data = mem_q[load_sel][load_idx] ^ load_mask;
  end

  always_comb begin
    state_nxt = state_q;
    if (in_fire) begin
      if (beat_q == '0) state_nxt[fill_sel_q] = BUF_FILLING;
      if (beat_last)    state_nxt[fill_sel_q] = BUF_FULL;
    end
    if (drain_done) state_nxt[drain_sel_q] = BUF_EMPTY;
    if (load_first) state_nxt[load_sel] = BUF_DRAINING;
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem_q[fill_sel_q][beat_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]     <= BUF_EMPTY;
      state_q[1]     <= BUF_EMPTY;
      meta_q[0]      <= '0;
      meta_q[1]      <= '0;
      fill_sel_q     <= 1'b0;
      drain_sel_q    <= 1'b0;
      beat_q         <= '0;
      rd_ptr_q       <= '0;
      syn_q          <= '0;
      par_q          <= 1'b0;
      page_en_q      <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      out_err_corr   <= 1'b0;
      out_err_uncorr <= 1'b0;
      out_err_word   <= '0;
      out_err_bit    <= '0;
      corr_cnt       <= '0;
      uncorr_cnt     <= '0;
    end else begin
      state_q <= state_nxt;
      if (in_fire) begin
        if (beat_q == '0) page_en_q <= cfg_ecc_en;
        if (beat_last) begin
          meta_q[fill_sel_q] <= meta_fin;
          fill_sel_q         <= ~fill_sel_q;
          beat_q             <= '0;
          syn_q              <= '0;
          par_q              <= 1'b0;
        end else begin
          beat_q <= beat_q + WORD_W'(1);
          syn_q  <= syn_q ^ word_syn;
          par_q  <= par_q ^ (^in_data);
        end
      end
      if (drain_done) begin
        drain_sel_q <= ~drain_sel_q;
        if (out_err_corr && corr_cnt != '1)     corr_cnt   <= corr_cnt + CNT_W'(1);
        if (out_err_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
      if (load_en) begin
        out_valid      <= 1'b1;
        out_data       <= load_data;
        out_last       <= (load_idx == WORD_W'(PAGE_WORDS - 1));
        out_err_corr   <= meta_q[load_sel].corr;
        out_err_uncorr <= meta_q[load_sel].uncorr;
        out_err_word   <= meta_q[load_sel].word;
        out_err_bit    <= meta_q[load_sel].bit_i;
        rd_ptr_q       <= load_idx;
      end else if (drain_done) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_page_ecc_decoder.sv
// Bench for sram_page_ecc_decoder: directed pages plus randomized traffic,
// scored against a page-level SECDED model through an expected-output queue.
module tb_sram_page_ecc_decoder;

  localparam int DATA_W     = 16;
  localparam int PAGE_WORDS = 8;
  localparam int CNT_W      = 16;
  localparam int N          = DATA_W * PAGE_WORDS;
  localparam int CHK_W      = 8;
  localparam int CODE_W     = CHK_W + 1;
  localparam int WORD_W     = 3;
  localparam int BIT_W      = 4;
  localparam int EXP_W      = DATA_W + 3 + WORD_W + BIT_W;

  logic              clk, rst_n, cfg_ecc_en, in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CODE_W-1:0] in_code;
  logic              out_valid, out_ready, out_last, out_err_corr, out_err_uncorr;
  logic [DATA_W-1:0] out_data;
  logic [WORD_W-1:0] out_err_word;
  logic [BIT_W-1:0]  out_err_bit;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
  logic [3:0]        dbg_buf_state;

  sram_page_ecc_decoder #(.DATA_W(DATA_W), .PAGE_WORDS(PAGE_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_ecc_en(cfg_ecc_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_err_corr(out_err_corr), .out_err_uncorr(out_err_uncorr),
    .out_err_word(out_err_word), .out_err_bit(out_err_bit),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .dbg_buf_state(dbg_buf_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int passes = 0;
  int pos_tab [N];
  logic [EXP_W-1:0] exp_q [$];
  logic [EXP_W-1:0] mon_e;
  int exp_corr = 0;
  int exp_uncorr = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // reference model
  task automatic build_pos();
    int p;
    p = 3;
    for (int i = 0; i < N; i++) begin
      while ((p & (p - 1)) == 0) p++;
      pos_tab[i] = p;
      p++;
    end
  endtask

  function automatic logic [CODE_W-1:0] encode(input logic [N-1:0] pg);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      if (pg[i])
        for (int k = 0; k < CHK_W; k++)
          if (((pos_tab[i] >> k) & 1) == 1) c[k] = ~c[k];
    c[CHK_W] = (^pg) ^ (^c[CHK_W-1:0]);
    return c;
  endfunction

  task automatic model_push(input logic [N-1:0] pg, input logic [CODE_W-1:0] code, input bit en);
    int s, found, fw, fb;
    bit p, corr, uncorr, pw;
    logic [N-1:0] outp;
    logic [DATA_W-1:0] w;
    s = 0; p = 0; corr = 0; uncorr = 0; fw = 0; fb = 0;
    outp = pg;
    for (int i = 0; i < N; i++) if (pg[i]) begin s = s ^ pos_tab[i]; p = ~p; end
    for (int k = 0; k < CHK_W; k++) if (code[k]) s = s ^ (1 << k);
    p = p ^ (^code);
    if (en && (s != 0 || p)) begin
      if (!p) uncorr = 1;
      else begin
        pw = (s == 0);
        for (int k = 0; k < CHK_W; k++) if (s == (1 << k)) pw = 1;
        if (pw) corr = 1;
        else begin
          found = -1;
          for (int i = 0; i < N; i++) if (pos_tab[i] == s) found = i;
          if (found >= 0) begin
            corr = 1; fw = found / DATA_W; fb = found % DATA_W;
            outp[found] = ~outp[found];
          end else uncorr = 1;
        end
      end
    end
    for (int i = 0; i < PAGE_WORDS; i++) begin
      w = outp[i*DATA_W +: DATA_W];
      exp_q.push_back({w, (i == PAGE_WORDS - 1), corr, uncorr, WORD_W'(fw), BIT_W'(fb)});
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] c, input logic en,
                            output bit ok);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_code = c; cfg_ecc_en = en;
    cnt = 0;
    while (!in_ready && cnt < 500) begin @(negedge clk); cnt++; end
    ok = in_ready;
    if (!ok) begin
      checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", cnt);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_page(input logic [N-1:0] pg, input logic [CODE_W-1:0] code, input bit en);
    bit ok;
    model_push(pg, code, en);
    for (int w = 0; w < PAGE_WORDS; w++) begin
      drive_beat(pg[w*DATA_W +: DATA_W],
                 (w == PAGE_WORDS - 1) ? code : CODE_W'($urandom),
                 (w == 0) ? en : 1'($urandom), ok);
      if (!ok) return;
    end
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 1000) begin @(negedge clk); cnt++; end
    check("drain_complete", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 out_ready = r;
  endtask

  function automatic logic [N-1:0] rand_page();
    logic [N-1:0] pg;
    for (int i = 0; i < N; i += 32) pg[i +: 32] = $urandom;
    return pg;
  endfunction

  always @(posedge clk) if (rand_ready) #1 out_ready = ($urandom_range(0, 3) != 0);

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("corr_cnt", corr_cnt, exp_corr);
      check("uncorr_cnt", uncorr_cnt, exp_uncorr);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got data 0x%0h with no expected word queued", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_word{data,last,corr,uncorr,word,bit}",
              {out_data, out_last, out_err_corr, out_err_uncorr, out_err_word, out_err_bit}, mon_e);
        if (mon_e[BIT_W+WORD_W+2] && mon_e[BIT_W+WORD_W+1]) exp_corr++;
        if (mon_e[BIT_W+WORD_W+2] && mon_e[BIT_W+WORD_W])   exp_uncorr++;
      end
    end
  end

  initial begin
    logic [N-1:0] pg, zero_pg;
    logic [CODE_W-1:0] code;
    bit ok;
    int mode, a, b;
    build_pos();
    zero_pg = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_code = '0; cfg_ecc_en = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_fields", {out_data, out_last, out_err_corr, out_err_uncorr, out_err_word, out_err_bit}, 0);
    check("reset_counters", {corr_cnt, uncorr_cnt}, 0);
    check("reset_buf_state", dbg_buf_state, 0);
    rst_n = 1'b1;
    set_ready(1'b1);

    // all-zero page, latency
    send_page(zero_pg, '0, 1'b1);
    @(negedge clk);
    check("latency_not_yet_valid", out_valid, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("latency_word0", out_data, 0);
    wait_drain();

    // single data-bit error at word 3 bit 5
    pg = rand_page();
    code = encode(pg);
    pg[53] = ~pg[53];
    send_page(pg, code, 1'b1);
    wait_drain();
    check("single_err_corr_cnt", corr_cnt, 1);

    // double data-bit error
    pg = rand_page();
    code = encode(pg);
    pg[0] = ~pg[0];
    pg[6*DATA_W + 15] = ~pg[6*DATA_W + 15];
    send_page(pg, code, 1'b1);
    wait_drain();
    check("double_err_uncorr_cnt", uncorr_cnt, 1);
    check("double_err_corr_cnt", corr_cnt, 1);

    // check-bit and overall-parity errors
    pg = rand_page();
    code = encode(pg);
    code[2] = ~code[2];
    send_page(pg, code, 1'b1);
    pg = rand_page();
    code = encode(pg);
    code[CHK_W] = ~code[CHK_W];
    send_page(pg, code, 1'b1);
    wait_drain();
    check("code_err_corr_cnt", corr_cnt, 3);

    // bypass leaves an erroneous page raw
    pg = rand_page();
    code = encode(pg) ^ CODE_W'(5);
    send_page(pg, code, 1'b0);
    wait_drain();
    check("bypass_counters", {corr_cnt, uncorr_cnt}, {CNT_W'(3), CNT_W'(1)});

    // back-pressure with three pages
    set_ready(1'b0);
    send_page(rand_page(), '0, 1'b1);
    @(negedge clk);
    check("bp_ready_after_page1", in_ready, 1);
    pg = rand_page();
    send_page(pg, encode(pg), 1'b1);
    @(negedge clk);
    check("bp_ready_after_16_beats", in_ready, 0);
    check("bp_out_valid_stalled", out_valid, 1);
    pg = rand_page();
    code = encode(pg);
    pg[77] = ~pg[77];
    fork
      send_page(pg, code, 1'b1);
      begin
        repeat (6) @(negedge clk);
        set_ready(1'b1);
      end
    join
    wait_drain();

    // randomized traffic
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      pg = rand_page();
      code = encode(pg);
      mode = $urandom_range(0, 4);
      a = $urandom_range(0, N - 1);
      b = (a + $urandom_range(1, N - 1)) % N;
      case (mode)
        1: pg[a] = ~pg[a];
        2: begin pg[a] = ~pg[a]; pg[b] = ~pg[b]; end
        3: code[a % CODE_W] = ~code[a % CODE_W];
        4: code = CODE_W'($urandom);
        default: ;
      endcase
      send_page(pg, code, ($urandom_range(0, 4) != 0));
    end
    rand_ready = 0;
    set_ready(1'b1);
    wait_drain();

    // asynchronous reset mid-page with a stalled output
    set_ready(1'b0);
    pg = rand_page();
    code = encode(pg);
    pg[9] = ~pg[9];
    send_page(pg, code, 1'b1);
    for (int w = 0; w < 3; w++) begin
      drive_beat(DATA_W'($urandom), '0, 1'b1, ok);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h5a5a;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_fields", {out_data, out_last, out_err_corr, out_err_uncorr, out_err_word, out_err_bit}, 0);
    check("async_rst_counters", {corr_cnt, uncorr_cnt}, 0);
    check("async_rst_buf_state", dbg_buf_state, 0);
    in_valid = 1'b0;
    exp_q.delete();
    exp_corr = 0;
    exp_uncorr = 0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pg = rand_page();
    send_page(pg, encode(pg), 1'b1);
    wait_drain();
    check("post_reset_idle", out_valid, 0);
    check("post_reset_counters", {corr_cnt, uncorr_cnt}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
